// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder family.
//
// Contents:
//   state_t    - responder FSM states (IDLE, READ, WAIT, DONE)
//   byte_count - number of bytes in a request: the extra-bytes field plus one.
//                Callers size the result to EXTRA+1 bits so that a full-word
//                request (extra = all ones) still fits.

package mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic int unsigned byte_count(input int unsigned extra);
      return extra + 1;
   endfunction

endpackage

// File: rtl/mem_bounds_check.sv
// Combinational window check shared by the memory responders.
//
// A request covering bytes addr .. addr+extra is out of window when it starts
// below lower_bound or ends above upper_bound. The end address is formed one
// bit wider than the address so it can never wrap back into the window.
//
// Ports:
//   addr        in   AW+1   first byte address of the request
//   extra       in   EXTRA  bytes beyond the first
//   lower_bound in   AW+1   lowest legal byte address (inclusive)
//   upper_bound in   AW+1   highest legal byte address (inclusive)
//   error       out  1      request falls (partly) outside the window

module mem_bounds_check #(
   parameter int AW    = 4,
   parameter int EXTRA = 4
) (
   input  logic [AW:0]      addr,
   input  logic [EXTRA-1:0] extra,
   input  logic [AW:0]      lower_bound,
   input  logic [AW:0]      upper_bound,
   output logic             error
);

   logic [AW+1:0] last_addr;

   // End address of the request, widened so addr+extra cannot overflow.
   assign last_addr = (AW+2)'(addr) + (AW+2)'(extra);

   // An inverted window (lower > upper) fails one of these two tests for
   // every address, so it needs no separate handling.
   assign error = (addr < lower_bound) || (last_addr > (AW+2)'(upper_bound));

endmodule

// File: rtl/mem_responder.sv
// Multi-byte read responder in front of an external byte-wide RAM.
//
// A request (req in IDLE) reads extra+1 consecutive bytes starting at addr,
// one RAM address per READ cycle, and assembles them little-endian into data.
// The RAM answers one cycle after each address, so a WAIT cycle follows the
// last READ to collect the final byte. Requests outside the inclusive window
// lower_bound..upper_bound skip the RAM entirely and complete with error.
//
// Ports:
//   clk         in   1            clock, all state changes on rising edge
//   reset       in   1            asynchronous, active-low reset
//   req         in   1            read request, sampled only in IDLE
//   addr        in   AW+1         first byte address
//   extra       in   EXTRA        bytes to read beyond the first
//   lower_bound in   AW+1         legal window start (inclusive)
//   upper_bound in   AW+1         legal window end (inclusive)
//   data        out  2**EXTRA*8   little-endian read result
//   error       out  1            last request was out of window
//   ack         out  1            one-cycle completion pulse
//   busy        out  1            responder is not idle
//   ram_addr    out  AW+1         byte address presented to the RAM
//   ram_rdata   in   8            RAM byte, valid one cycle after ram_addr

module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int AW    = 4,
   parameter int EXTRA = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req,
   input  logic [AW:0]            addr,
   input  logic [EXTRA-1:0]       extra,
   input  logic [AW:0]            lower_bound,
   input  logic [AW:0]            upper_bound,
   output logic [(2**EXTRA)*8-1:0] data,
   output logic                   error,
   output logic                   ack,
   output logic                   busy,
   output logic [AW:0]            ram_addr,
   input  logic [7:0]             ram_rdata
);

   state_t           state;
   logic [EXTRA-1:0] extra_q;
   logic [EXTRA-1:0] byte_idx;
   logic [EXTRA-1:0] cap_idx;
   logic             cap_valid;
   logic [EXTRA:0]   n_bytes;
   logic             last_byte;
   logic             range_err;

   mem_bounds_check #(
      .AW    (AW),
      .EXTRA (EXTRA)
   ) u_bounds (
      .addr        (addr),
      .extra       (extra),
      .lower_bound (lower_bound),
      .upper_bound (upper_bound),
      .error       (range_err)
   );

   // Byte count is EXTRA+1 bits wide so a full-word request does not wrap;
   // the index itself only ever reaches n_bytes-1 and fits in EXTRA bits.
   assign n_bytes   = (EXTRA+1)'(byte_count(32'(extra_q)));
   assign last_byte = ({1'b0, byte_idx} == (n_bytes - (EXTRA+1)'(1)));

   // Status outputs are decoded straight from the state so that reset
   // clears them the instant it is asserted.
   assign busy = (state != ST_IDLE);
   assign ack  = (state == ST_DONE);

   // Main sequencer. Each READ cycle issues one RAM address and remembers
   // which byte lane it belongs to (cap_idx/cap_valid); the RAM's answer
   // arrives a cycle later and is written into that lane, which is why the
   // last byte is collected during WAIT. ram_addr is only moved on accept
   // and while reading, so it holds its last value while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         extra_q   <= '0;
         byte_idx  <= '0;
         cap_idx   <= '0;
         cap_valid <= 1'b0;
         data      <= '0;
         error     <= 1'b0;
         ram_addr  <= '0;
      end else begin
         cap_valid <= 1'b0;
         if (cap_valid) begin
            data[{cap_idx, 3'b000} +: 8] <= ram_rdata;
         end

         case (state)
            ST_IDLE: begin
               if (req) begin
                  data     <= '0;
                  extra_q  <= extra;
                  byte_idx <= '0;
                  if (range_err) begin
                     error <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     error    <= 1'b0;
                     ram_addr <= addr;
                     state    <= ST_READ;
                  end
               end
            end

            ST_READ: begin
               cap_valid <= 1'b1;
               cap_idx   <= byte_idx;
               if (last_byte) begin
                  state <= ST_WAIT;
               end else begin
                  byte_idx <= byte_idx + (EXTRA)'(1);
                  ram_addr <= ram_addr + (AW+1)'(1);
               end
            end

            ST_WAIT: begin
               state <= ST_DONE;
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a byte RAM whose byte i holds
// 8'h10+i and answers one cycle after the address. Expected results come
// from a transaction-level model: error from the window rule, completion
// time from the byte count, and the data word assembled from the RAM pattern.

module tb_mem_responder;

   localparam int AW    = 4;
   localparam int EXTRA = 4;
   localparam int DW    = (2**EXTRA)*8;

   logic             clk;
   logic             reset;
   logic             req;
   logic [AW:0]      addr;
   logic [EXTRA-1:0] extra;
   logic [AW:0]      lower_bound;
   logic [AW:0]      upper_bound;
   logic [DW-1:0]    data;
   logic             error;
   logic             ack;
   logic             busy;
   logic [AW:0]      ram_addr;
   logic [7:0]       ram_rdata;

   int checkCount;
   int passCount;

   mem_responder #(
      .AW    (AW),
      .EXTRA (EXTRA)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .addr        (addr),
      .extra       (extra),
      .lower_bound (lower_bound),
      .upper_bound (upper_bound),
      .data        (data),
      .error       (error),
      .ack         (ack),
      .busy        (busy),
      .ram_addr    (ram_addr),
      .ram_rdata   (ram_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backing RAM: byte i = 8'h10 + i, one cycle of read latency.
   always @(posedge clk) begin
      ram_rdata <= 8'h10 + {3'b000, ram_addr};
   end

   // Counts every comparison and reports any that disagree.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Data word a legal read of bytes a..a+x returns.
   function automatic logic [127:0] modelData(input int a, input int x);
      logic [127:0] d;
      d = '0;
      for (int i = 0; i <= x; i++) begin
         d[8*i +: 8] = 8'(8'h10 + a + i);
      end
      return d;
   endfunction

   // One complete transaction: request, follow it to ack, check the result.
   task automatic applyStimulus(input int a, input int x, input int lo, input int hi);
      bit           expErr;
      int           n;
      int           expLat;
      int           edges;
      logic [127:0] expData;
      logic [AW:0]  addrBefore;

      expErr  = (a < lo) || (a + x > hi);
      n       = x + 1;
      expLat  = expErr ? 0 : n + 1;
      expData = expErr ? 128'd0 : modelData(a, x);

      @(negedge clk);
      addrBefore  = ram_addr;
      checkOutput("idle_before", 128'(busy), 128'd0);
      addr        = (AW+1)'(a);
      extra       = EXTRA'(x);
      lower_bound = (AW+1)'(lo);
      upper_bound = (AW+1)'(hi);
      req         = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;

      edges = 0;
      while (!ack && edges < 40) begin
         if (!expErr && edges < n) begin
            checkOutput("ram_addr", 128'(ram_addr), 128'(a + edges));
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      checkOutput("ack_latency", 128'(edges), 128'(expLat));
      checkOutput("error", 128'(error), 128'(expErr));
      checkOutput("data", data, expData);
      if (expErr) begin
         checkOutput("ram_addr_hold", 128'(ram_addr), 128'(addrBefore));
      end

      @(posedge clk);
      @(negedge clk);
      checkOutput("ack_width", 128'(ack), 128'd0);
      checkOutput("busy_after", 128'(busy), 128'd0);
      checkOutput("data_hold", data, expData);
      checkOutput("error_hold", 128'(error), 128'(expErr));
   endtask

   initial begin
      int lo;
      int hi;
      int n42;
      int expCount;
      int ackSeen[$];

      checkCount  = 0;
      passCount   = 0;
      reset       = 1'b0;
      req         = 1'b0;
      addr        = '0;
      extra       = '0;
      lower_bound = '0;
      upper_bound = 5'd31;

      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 128'(busy), 128'd0);
      checkOutput("rst_ack", 128'(ack), 128'd0);
      checkOutput("rst_data", data, 128'd0);
      checkOutput("rst_error", 128'(error), 128'd0);
      checkOutput("rst_ram_addr", 128'(ram_addr), 128'd0);
      @(posedge clk);
      #2 reset = 1'b1;

      applyStimulus(3, 0, 0, 31);
      applyStimulus(0, 15, 0, 31);
      applyStimulus(30, 3, 0, 31);
      applyStimulus(7, 0, 8, 31);
      applyStimulus(6, 0, 8, 5);

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            lo = int'($urandom_range(0, 31));
            hi = int'($urandom_range(0, 31));
         end else begin
            lo = 0;
            hi = 31;
         end
         applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), lo, hi);
      end

      // req held high: a new accept needs DONE->IDLE plus an IDLE edge.
      n42 = 3;
      @(negedge clk);
      addr        = 5'd4;
      extra       = 4'd2;
      lower_bound = 5'd0;
      upper_bound = 5'd31;
      req         = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack) begin
            ackSeen.push_back(cyc);
            checkOutput("held_data", data, modelData(4, 2));
         end
      end
      expCount = 0;
      for (int j = 0; (n42 + 1) + j * (n42 + 3) < 30; j++) begin
         expCount++;
      end
      checkOutput("held_ack_count", 128'(ackSeen.size()), 128'(expCount));
      for (int j = 0; j < ackSeen.size(); j++) begin
         checkOutput("held_ack_slot", 128'(ackSeen[j]), 128'((n42 + 1) + j * (n42 + 3)));
      end

      // Drain, then reset during READ cycle 1.
      req = 1'b0;
      for (int g = 0; g < 10 && busy; g++) begin
         @(negedge clk);
      end
      checkOutput("drain_idle", 128'(busy), 128'd0);
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      checkOutput("accept_busy", 128'(busy), 128'd1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("midrst_busy", 128'(busy), 128'd0);
      checkOutput("midrst_ack", 128'(ack), 128'd0);
      checkOutput("midrst_data", data, 128'd0);
      checkOutput("midrst_error", 128'(error), 128'd0);
      checkOutput("midrst_ram_addr", 128'(ram_addr), 128'd0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("midrst_no_ack", 128'(ack), 128'd0);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      applyStimulus(3, 0, 0, 31);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
